// File: rtl/serial_pkg.sv
// Shared types, constants and helpers for the serial frame receiver.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Returns 1 when the word has an odd number of ones.
  // Callers zero-extend narrower words, which leaves the result unchanged.
  function automatic logic even_parity(input logic [15:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serial_frame_rx_sipo.sv
// Serial-in parallel-out shift register; new bits enter at the LSB.
module sipo_shift_reg #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              din,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[DATA_W-2:0], din};
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W payload bits MSB first, optional even
// parity (SERIAL_FRAME_RX_PARITY_EN), stop bit; output held under a valid/ready handshake.
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  input  logic              bit_en,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);

  // Handshake: data_out is transferred on any clk edge where out_valid and
  // out_ready are both 1; data_out is held stable while out_valid=1, out_ready=0.

  rx_state_t          state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DATA_W-1:0]  sr_q;
  logic               sr_clr;
  logic               sr_shift;
  logic               stop_edge;
  logic               frame_good;
  logic               frame_bad;

  assign sr_clr   = bit_en && (state == IDLE) && (serial_in == START_BIT);
  assign sr_shift = bit_en && (state == DATA);

  sipo_shift_reg #(.DATA_W(DATA_W)) u_sipo (
    .clk      (clk),
    .rst      (rst),
    .clr      (sr_clr),
    .shift_en (sr_shift),
    .din      (serial_in),
    .q        (sr_q)
  );

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic par_ok;
  assign frame_good = stop_edge && (serial_in == STOP_BIT) && par_ok;
`else
  assign frame_good = stop_edge && (serial_in == STOP_BIT);
`endif

  assign stop_edge = bit_en && (state == STOP);
  assign frame_bad = stop_edge && !frame_good;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_ok    <= 1'b1;
`endif
    end else begin
      // A good frame may reload on the same edge the previous word is consumed.
      if (frame_good && (!out_valid || out_ready)) begin
        data_out  <= sr_q;
        out_valid <= 1'b1;
      end else begin
        if (frame_good) overrun <= 1'b1;
        if (out_valid && out_ready) out_valid <= 1'b0;
      end
      if (frame_bad) frame_err <= 1'b1;

      if (bit_en) begin
        case (state)
          IDLE: begin
            if (serial_in == START_BIT) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              bit_cnt <= '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
`ifdef SERIAL_FRAME_RX_PARITY_EN
          PARITY: begin
            par_ok <= (even_parity(16'(sr_q)) ^ serial_in) == 1'b0;
            state  <= STOP;
          end
`endif
          STOP: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
